multi_edge_detector: RTL and testbench
======================================

// Module: multi_edge_detector
// PURPOSE
//  CH-channel synchronised edge detector; successor to the single-channel positive-edge detector.
//  Per-channel mode: off / rise / fall / both. Per channel: 1-cycle tick, sticky pending flag,
//  saturating event counter. Sits between asynchronous level inputs and control logic.
//  Aggregated irq output for the interrupt path.
// PARAMETERS
//  CH          4  number of independent channels (>=1)
//  SYNC_STAGES 2  input synchroniser flops per channel (>=2)
//  CNT_W       8  event counter width per channel (>=1)
//  DB_CYCLES   4  debounce stable-sample count (used only with EDGE_DEBOUNCE_EN, >=2)
// PORTS
//  clk    in  1        single clock, all logic on posedge
//  rst    in  1        synchronous reset, active-high
//  level  in  CH       asynchronous level inputs, channel i = bit i
//  mode   in  2*CH     channel i mode = mode[2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//  clr    in  CH       clear pend[i] and count[i] (synchronous, level-sensitive)
//  tick   out CH       1-cycle pulse per qualified edge, registered
//  pend   out CH       sticky flag, set by tick, cleared by clr
//  count  out CH*CNT_W channel i = count[i*CNT_W +: CNT_W], saturating qualified-edge count
//  irq    out 1        |pend, registered
// BEHAVIOUR
//  - Reset (rst=1 at posedge): sync chain, history, tick, pend, count, irq all 0; warm-up counter
//    loaded. Reset mid-operation behaves identically; in-flight edges are discarded.
//  - Pipeline: level -> SYNC_STAGES flops -> s; prev <= s each cycle.
//    rise = s&~prev, fall = ~s&prev. tick <= qualified edge, per mode.
//  - Latency: level change set up before posedge k -> tick high in cycle after posedge k+SYNC_STAGES.
//    Exactly one cycle wide per edge.
//  - Warm-up: after rst deasserts, ticks are suppressed for SYNC_STAGES+1 cycles while history
//    fills. Input already high at reset release gives no tick.
//  - Mode: sampled every cycle. Mode 00 suppresses tick/pend/count only; history keeps tracking,
//    so switching mode never creates a spurious edge. A mode change takes effect on the next
//    evaluated edge.
//  - Minimum pulse: level pulses shorter than one clk may be missed; no guarantee.
//  - Back-to-back: toggle every cycle in mode 11 -> tick held high on consecutive cycles,
//    count +1 per cycle.
//  - pend: qualified edge sets it; clr clears it. Simultaneous edge and clr -> pend=1 (set wins).
//  - count: +1 per qualified edge, saturates at 2**CNT_W-1 (no wrap).
//    Simultaneous edge and clr -> count=1. clr alone -> 0.
//  - irq updates one cycle after pend changes.
// CONFIGURATION
//  EDGE_DEBOUNCE_EN defined:
//    - Per-channel filter after the synchroniser. Filtered s changes only after DB_CYCLES
//      consecutive identical synchronised samples that differ from current s.
//    - Counter width $clog2(DB_CYCLES+1). Glitches shorter than DB_CYCLES are rejected.
//    - Latency grows by DB_CYCLES cycles. Warm-up grows to SYNC_STAGES+DB_CYCLES+1.
//  EDGE_DEBOUNCE_EN undefined: no filter; s is the last synchroniser flop; DB_CYCLES ignored.
// STRUCTURE
//  - Package edge_pkg:
//    - typedef enum logic[1:0] edge_mode_t {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH}
//    - localparam EDGE_MODE_W = 2
//  - Sub-module edge_chan: one channel (sync chain, optional debounce, history, tick/pend/count).
//    Instantiated CH times in a generate loop. Top holds the warm-up counter and irq OR-reduce.
// TESTING (CH=4, SYNC_STAGES=2, CNT_W=4, clk period 20)
//  1. rst=1 for 2 cycles with level=4'hF, mode=all 11. Release -> tick=0, pend=0, count=0, irq=0
//     through warm-up and after.
//  2. ch0 mode 01, level[0] 0->1 before posedge k -> tick[0]=1 for one cycle after posedge k+2.
//     Then pend[0]=1, count[0]=1, irq=1 next cycle. level[0] 1->0 -> no tick.
//  3. ch1 mode 10 and ch2 mode 11. Toggle both inputs high then low -> ch1 one tick (fall);
//     ch2 two ticks, count[2]=2.
//  4. ch3 mode 11, 20 toggles -> count[3] saturates at 15. Assert clr[3] in the same cycle as a
//     tick -> count[3]=1, pend[3]=1. clr[3] alone next -> 0, 0.
//  5. ch0 mode 00, raise level[0], switch mode to 01 while high -> no tick. Next rise ticks.
//     Assert rst while a rise is in the sync chain -> no tick emitted.
//  6. EDGE_DEBOUNCE_EN, DB_CYCLES=4: 3-cycle glitch on level[1] -> no tick. 6-cycle high ->
//     exactly one tick, latency 2+4+1 cycles.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Mode encoding: 00 off, 01 rise, 10 fall, 11 both.
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int EDGE_MODE_W = 2;

  function automatic logic edge_qualify(input edge_mode_t mode, input logic rise, input logic fall);
    logic hit;
    case (mode)
      EDGE_OFF:  hit = 1'b0;
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One detector channel: synchroniser, optional debounce filter (EDGE_DEBOUNCE_EN),
// edge history, registered tick, sticky pend and saturating event counter.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
`ifdef EDGE_DEBOUNCE_EN
  , parameter int DB_CYCLES = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_level,
  input  edge_mode_t       i_mode,
  input  logic             i_clr,
  input  logic             i_arm,
  output logic             o_tick,
  output logic             o_pend,
  output logic [CNT_W-1:0] o_count
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic                   r_prev;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_hit;
  logic                   r_tick;
  logic                   r_pend;
  logic [CNT_W-1:0]       r_count;

  // Input synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_level};
    end
  end

`ifdef EDGE_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);

  logic [DB_W-1:0] r_db_cnt;
  logic            r_filt;

  // Filtered level flips only after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_filt   <= 1'b0;
    end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_W'(DB_CYCLES - 1)) begin
      r_db_cnt <= '0;
      r_filt   <= r_sync[SYNC_STAGES-1];
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_s = r_filt;
`else
  assign w_s = r_sync[SYNC_STAGES-1];
`endif

  assign w_rise = w_s & ~r_prev;
  assign w_fall = ~w_s & r_prev;
  assign w_hit  = i_arm & edge_qualify(i_mode, w_rise, w_fall);

  // History, tick, sticky flag and counter; a tick landing with clr wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_tick  <= 1'b0;
      r_pend  <= 1'b0;
      r_count <= '0;
    end else begin
      r_prev <= w_s;
      r_tick <= w_hit;
      r_pend <= r_tick | (r_pend & ~i_clr);
      if (i_clr) begin
        r_count <= CNT_W'(r_tick);
      end else if (r_tick && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + CNT_W'(1);
      end else begin
        r_count <= r_count;
      end
    end
  end

  assign o_tick  = r_tick;
  assign o_pend  = r_pend;
  assign o_count = r_count;

endmodule

// File: rtl/multi_edge_detector.sv
// CH-channel synchronised edge detector with warm-up suppression and aggregated irq.
// Optional per-channel debounce filter enabled by defining EDGE_DEBOUNCE_EN.
module multi_edge_detector
  import edge_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int DB_CYCLES   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       level,
  input  logic [2*CH-1:0]     mode,
  input  logic [CH-1:0]       clr,
  output logic [CH-1:0]       tick,
  output logic [CH-1:0]       pend,
  output logic [CH*CNT_W-1:0] count,
  output logic                irq
);

`ifdef EDGE_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  // History is not trustworthy until the sync chain (and filter) has refilled
  localparam int WARM   = SYNC_STAGES + 1 + (DB_EN ? DB_CYCLES : 0);
  localparam int WARM_W = $clog2(WARM + 1);

  logic [WARM_W-1:0] r_warm;
  logic              w_arm;
  logic              r_irq;

  // Warm-up down-counter, reloaded by every reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_warm <= WARM_W'(WARM);
    end else if (r_warm != '0) begin
      r_warm <= r_warm - WARM_W'(1);
    end else begin
      r_warm <= r_warm;
    end
  end

  assign w_arm = (r_warm == '0);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
`ifdef EDGE_DEBOUNCE_EN
      , .DB_CYCLES(DB_CYCLES)
`endif
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .i_level(level[i]),
      .i_mode (edge_mode_t'(mode[EDGE_MODE_W*i +: EDGE_MODE_W])),
      .i_clr  (clr[i]),
      .i_arm  (w_arm),
      .o_tick (tick[i]),
      .o_pend (pend[i]),
      .o_count(count[i*CNT_W +: CNT_W])
    );
  end

  // Interrupt follows the pending flags one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |pend;
    end
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Randomised + directed bench for multi_edge_detector against a cycle-indexed reference model.
// The model reasons over the history of applied levels since reset release.
module tb_multi_edge_detector;

  localparam int CH    = 4;
  localparam int SYNC  = 2;
  localparam int CNT_W = 4;
  localparam int DB    = 4;
`ifdef EDGE_DEBOUNCE_EN
  localparam bit DB_ON = 1'b1;
  localparam int WARM  = SYNC + DB + 1;
`else
  localparam bit DB_ON = 1'b0;
  localparam int WARM  = SYNC + 1;
`endif
  localparam int MAXC = (1 << CNT_W) - 1;

  logic                clk;
  logic                rst;
  logic [CH-1:0]       level;
  logic [2*CH-1:0]     mode;
  logic [CH-1:0]       clr;
  logic [CH-1:0]       tick;
  logic [CH-1:0]       pend;
  logic [CH*CNT_W-1:0] count;
  logic                irq;

  multi_edge_detector #(
    .CH(CH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W), .DB_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .level(level), .mode(mode), .clr(clr),
    .tick(tick), .pend(pend), .count(count), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Per-posedge histories since reset release: applied level, synchronised value, detector input
  logic [CH-1:0] lev_h[$];
  logic [CH-1:0] syn_h[$];
  logic [CH-1:0] s_h[$];
  logic [CH-1:0] m_tick = '0;
  logic [CH-1:0] m_pend = '0;
  logic          m_irq  = 1'b0;
  int            m_cnt[CH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [CH-1:0] syn_at(input int idx);
    if (idx < 0) return '0;
    return syn_h[idx];
  endfunction

  function automatic logic [CH-1:0] s_at(input int idx);
    if (idx < 0) return '0;
    return s_h[idx];
  endfunction

  task automatic model_step(input logic r, input logic [CH-1:0] l,
                            input logic [2*CH-1:0] m, input logic [CH-1:0] c);
    logic [CH-1:0] syn, s_new, t_new, prv, cur, win;
    logic [1:0]    md;
    logic          run;
    int            n;
    if (r) begin
      lev_h.delete(); syn_h.delete(); s_h.delete();
      m_tick = '0; m_pend = '0; m_irq = 1'b0;
      for (int i = 0; i < CH; i++) m_cnt[i] = 0;
      cyc = 0;
      return;
    end
    lev_h.push_back(l);
    syn = (cyc >= SYNC - 1) ? lev_h[cyc-SYNC+1] : '0;
    syn_h.push_back(syn);
    s_new = syn;
    if (DB_ON) begin
      s_new = s_at(cyc - 1);
      for (int i = 0; i < CH; i++) begin
        run = 1'b1;
        for (int j = 0; j < DB; j++) begin
          win = syn_at(cyc - 1 - j);
          if (win[i] == s_new[i]) run = 1'b0;
        end
        if (run) s_new[i] = ~s_new[i];
      end
    end
    prv = s_at(cyc - 2);
    cur = s_at(cyc - 1);
    for (int i = 0; i < CH; i++) begin
      md = m[2*i +: 2];
      t_new[i] = (cyc >= WARM) && ((md[0] && cur[i] && !prv[i]) || (md[1] && !cur[i] && prv[i]));
      if (c[i]) n = int'(m_tick[i]);
      else      n = m_cnt[i] + int'(m_tick[i]);
      m_cnt[i] = (n > MAXC) ? MAXC : n;
    end
    m_irq  = |m_pend;
    m_pend = (m_pend & ~c) | m_tick;
    m_tick = t_new;
    s_h.push_back(s_new);
    cyc++;
  endtask

  task automatic step(input logic r, input logic [CH-1:0] l,
                      input logic [2*CH-1:0] m, input logic [CH-1:0] c);
    logic [CH*CNT_W-1:0] exp_cnt;
    rst = r; level = l; mode = m; clr = c;
    @(posedge clk);
    model_step(r, l, m, c);
    @(negedge clk);
    for (int i = 0; i < CH; i++) exp_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    chk("tick",  64'(tick),  64'(m_tick));
    chk("pend",  64'(pend),  64'(m_pend));
    chk("count", 64'(count), 64'(exp_cnt));
    chk("irq",   64'(irq),   64'(m_irq));
  endtask

  task automatic hold(input logic r, input logic [CH-1:0] l,
                      input logic [2*CH-1:0] m, input logic [CH-1:0] c, input int n);
    for (int k = 0; k < n; k++) step(r, l, m, c);
  endtask

  logic [CH-1:0]   lv;
  logic [2*CH-1:0] md;
  logic [CH-1:0]   cl;
  logic            rr;

  initial begin
    // Reset with inputs high, then release: nothing may fire during or after warm-up
    hold(1'b1, 4'hF, 8'hFF, 4'h0, 2);
    hold(1'b0, 4'hF, 8'hFF, 4'h0, 10);
    // ch0 rise-only: rise ticks once, fall is ignored
    hold(1'b0, 4'h0, 8'h01, 4'h0, 6);
    hold(1'b0, 4'h1, 8'h01, 4'h0, 6);
    hold(1'b0, 4'h0, 8'h01, 4'h0, 6);
    // ch1 fall-only, ch2 both
    hold(1'b0, 4'h6, 8'h38, 4'h0, 5);
    hold(1'b0, 4'h0, 8'h38, 4'h0, 6);
    // ch3 both: back-to-back toggles saturate the counter, then clr with and without a tick
    lv = 4'h0;
    for (int k = 0; k < 20; k++) begin
      lv = lv ^ 4'h8;
      step(1'b0, lv, 8'hC0, 4'h0);
    end
    step(1'b0, lv, 8'hC0, 4'h8);
    hold(1'b0, lv, 8'hC0, 4'h0, 4);
    step(1'b0, lv, 8'hC0, 4'h8);
    hold(1'b0, lv, 8'hC0, 4'h0, 3);
    // ch0 off while rising, then enabled while high: only the later rise counts
    hold(1'b0, 4'h0, 8'h00, 4'hF, 4);
    hold(1'b0, 4'h1, 8'h00, 4'h0, 5);
    hold(1'b0, 4'h1, 8'h01, 4'h0, 5);
    hold(1'b0, 4'h0, 8'h01, 4'h0, 5);
    hold(1'b0, 4'h1, 8'h01, 4'h0, 6);
    // Reset with a rise still in the synchroniser
    hold(1'b0, 4'h0, 8'h01, 4'h0, 5);
    hold(1'b0, 4'h1, 8'h01, 4'h0, 1);
    hold(1'b1, 4'h1, 8'h01, 4'h0, 2);
    hold(1'b0, 4'h1, 8'h01, 4'h0, 8);
    // Random phase: dense toggling first, then sparser with occasional clr/mode/reset
    lv = 4'h0; md = 8'hFF;
    for (int k = 0; k < 500; k++) begin
      if (k < 150) lv = lv ^ CH'($urandom);
      else         lv = lv ^ (CH'($urandom) & CH'($urandom));
      if ($urandom_range(0, 19) == 0) md = 8'($urandom);
      cl = ($urandom_range(0, 11) == 0) ? CH'($urandom) : 4'h0;
      rr = ($urandom_range(0, 149) == 0);
      step(rr, lv, md, cl);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
